// File: rtl/gpu_mem_combinator_ctrl.sv
// Sequencer for the 32-byte GPU memory combinator: holds the weight bank,
// assembles a payload block, captures the combinator result and streams it.
module gpu_mem_combinator_ctrl #(
    parameter int WORD_W = 16,
    parameter int N_PAY  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [WORD_W-1:0]          w_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WORD_W-1:0]          in_data,
    output logic [N_PAY*WORD_W-1:0]    comb_payload,
    output logic [2*N_PAY*WORD_W-1:0]  comb_weights,
    input  logic [2*N_PAY*WORD_W-1:0]  comb_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_last,
    output logic                       weights_loaded,
    output logic                       busy,
    output logic [CNT_W-1:0]           blocks_done
);

    localparam int NW   = 2 * N_PAY;
    localparam int WI_W = $clog2(NW);
    localparam int PI_W = (N_PAY > 1) ? $clog2(N_PAY) : 1;

    localparam logic [WI_W-1:0] W_LAST = WI_W'(NW - 1);
    localparam logic [PI_W-1:0] P_LAST = PI_W'(N_PAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLOAD,
        CAPTURE,
        DRAIN
    } state_t;

    state_t             state_q;
    logic [WORD_W-1:0]  bank_q [NW];
    logic [WORD_W-1:0]  pay_q  [N_PAY];
    logic [WORD_W-1:0]  obuf_q [NW];
    logic [WI_W-1:0]    w_idx_q;
    logic [PI_W-1:0]    p_idx_q;
    logic [WI_W-1:0]    o_idx_q;
    logic               wl_q;
    logic [CNT_W-1:0]   blk_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [WORD_W-1:0]  out_data_q;

    logic               w_fire;
    logic               in_fire;
    logic               o_fire;
    logic [WI_W-1:0]    o_idx_d;

    // A pending weight reload always wins over starting a new block.
    assign w_ready  = (state_q == IDLE);
    assign in_ready = ((state_q == IDLE) && wl_q && !w_valid)
                    || (state_q == PLOAD);

    assign w_fire  = w_valid && w_ready;
    assign in_fire = in_valid && in_ready;
    assign o_fire  = out_valid_q && out_ready;
    assign o_idx_d = o_idx_q + WI_W'(1);

    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;
    assign out_data       = out_data_q;
    assign weights_loaded = wl_q;
    assign busy           = (state_q != IDLE);
    assign blocks_done    = blk_q;

    always_comb begin
        comb_payload = '0;
        comb_weights = '0;
        for (int i = 0; i < N_PAY; i++) begin
            comb_payload[i*WORD_W +: WORD_W] = pay_q[i];
        end
        for (int k = 0; k < NW; k++) begin
            comb_weights[k*WORD_W +: WORD_W] = bank_q[k];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            w_idx_q     <= '0;
            p_idx_q     <= '0;
            o_idx_q     <= '0;
            wl_q        <= 1'b0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < NW; k++) begin
                bank_q[k] <= '0;
                obuf_q[k] <= '0;
            end
            for (int i = 0; i < N_PAY; i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_fire) begin
                        bank_q[w_idx_q] <= w_data;
                        if (w_idx_q == W_LAST) begin
                            w_idx_q <= '0;
                            wl_q    <= 1'b1;
                        end else begin
                            w_idx_q <= w_idx_q + WI_W'(1);
                            if (w_idx_q == '0) begin
                                wl_q <= 1'b0;
                            end
                        end
                    end else if (in_fire) begin
                        pay_q[0] <= in_data;
                        p_idx_q  <= PI_W'(1);
                        state_q  <= PLOAD;
                    end
                end
                PLOAD: begin
                    if (in_fire) begin
                        pay_q[p_idx_q] <= in_data;
                        if (p_idx_q == P_LAST) begin
                            p_idx_q <= '0;
                            state_q <= CAPTURE;
                        end else begin
                            p_idx_q <= p_idx_q + PI_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    for (int k = 0; k < NW; k++) begin
                        obuf_q[k] <= comb_out[k*WORD_W +: WORD_W];
                    end
                    o_idx_q     <= '0;
                    out_valid_q <= 1'b1;
                    out_last_q  <= 1'b0;
                    out_data_q  <= comb_out[0 +: WORD_W];
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (o_fire) begin
                        if (o_idx_q == W_LAST) begin
                            o_idx_q     <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_data_q  <= '0;
                            blk_q       <= blk_q + CNT_W'(1);
                            state_q     <= IDLE;
                        end else begin
                            o_idx_q    <= o_idx_d;
                            out_data_q <= obuf_q[o_idx_d];
                            out_last_q <= (o_idx_d == W_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
